pc_btb_unit: RTL

- Program-counter unit for the pipelined core.
- Holds current_pc and selects the next PC each cycle from, in priority order: reset, EX-stage redirect, stall hold, then BTB prediction or sequential PC+4.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Entries are trained by resolved branches and jumps coming back from EX.
- Sits at the front of IF. Feeds the instruction memory address, and passes the prediction down the pipeline for mispredict checking.

---
 rtl/pc_btb_unit.sv | 73 +++++++
 1 files changed

// File: rtl/pc_btb_unit.sv
// pc_btb_unit: fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
module pc_btb_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              BTB_ENTRIES = 16,
    localparam int             IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] current_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [1:0]             ctr     [BTB_ENTRIES];
    logic [TAG_W-1:0]       tags    [BTB_ENTRIES];
    logic [XLEN-1:0]        targets [BTB_ENTRIES];

    logic [IDX_W-1:0] idx, u_idx;
    logic [TAG_W-1:0] tag, u_tag;
    logic             hit, u_hit, u_alloc;
    logic [1:0]       u_ctr, ctr_nxt;
    logic             unused_low;

    assign idx        = current_pc[IDX_W+1:2];
    assign tag        = current_pc[XLEN-1:IDX_W+2];
    assign u_idx      = upd_pc[IDX_W+1:2];
    assign u_tag      = upd_pc[XLEN-1:IDX_W+2];
    assign unused_low = ^upd_pc[1:0];

    always_comb begin
        hit         = valid[idx] && tags[idx] == tag;
        pred_taken  = hit && ctr[idx][1];
        pred_target = pred_taken ? targets[idx] : current_pc + XLEN'(4);
        u_hit       = valid[u_idx] && tags[u_idx] == u_tag;
        u_alloc     = upd_valid && !u_hit && upd_taken;
        u_ctr       = ctr[u_idx];
        ctr_nxt     = upd_taken ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'b01)
                                : (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'b01);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc <= RESET_PC;
            valid      <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr[i] <= 2'b01;
        end else begin
            current_pc <= redirect_valid ? redirect_pc : stall ? current_pc : pred_target;
            if (upd_valid && u_hit) ctr[u_idx] <= ctr_nxt;
            if (u_alloc) begin
                valid[u_idx] <= 1'b1;
                ctr[u_idx]   <= 2'b10;
            end
        end
    end

    // tag/target storage needs no reset: every read is qualified by valid
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            targets[u_idx] <= upd_target;
            if (!u_hit) tags[u_idx] <= u_tag;
        end
    end
endmodule
